// File: rtl/scroll_msg_sequencer_if.sv
// Symbol load port for the HEX scroll message sequencer.
// load_valid : a symbol is offered this cycle (master -> slave)
// load_sym   : 2-bit symbol code, 00=d 01=E 10=L 11=blank (master -> slave)
// load_ready : sequencer can store another symbol (slave -> master)
interface scroll_msg_sequencer_if;
    logic       load_valid;
    logic [1:0] load_sym;
    logic       load_ready;

    modport master (output load_valid, output load_sym, input load_ready);
    modport slave  (input load_valid, input load_sym, output load_ready);
endinterface

// File: rtl/scroll_msg_sequencer.sv
// Loadable, pausable message source for the six-digit HEX scroller.
// Stores up to MAX_LEN 2-bit symbols and presents a six-digit window that
// slides left one position every TICK_COUNT cycles over the message followed
// by three blanks.
// Ports:
//   CLOCK_50  : system clock (rising edge)
//   clr       : synchronous active-high reset
//   load      : symbol load port (valid/ready), slave side
//   start     : begin scrolling the stored message (IDLE only)
//   pause_tog : toggle between scrolling and paused
//   stop      : end scrolling and discard the message
//   busy      : high while scrolling or paused
//   msg_len   : number of stored symbols
//   step      : one-cycle pulse on each window advance
//   win       : digit codes, win[11:10]=HEX5 ... win[1:0]=HEX0
module scroll_msg_sequencer #(
    parameter int unsigned TICK_COUNT = 50000000,
    parameter int unsigned MAX_LEN    = 8
) (
    input  logic                         CLOCK_50,
    input  logic                         clr,
    scroll_msg_sequencer_if.slave        load,
    input  logic                         start,
    input  logic                         pause_tog,
    input  logic                         stop,
    output logic                         busy,
    output logic [3:0]                   msg_len,
    output logic                         step,
    output logic [11:0]                  win
);

    localparam int unsigned TICK_W     = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int unsigned LEN_W      = 4;
    localparam int unsigned SYM_W      = 2;
    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned WIN_W      = NUM_DIGITS * SYM_W;
    localparam int unsigned NUM_BLANKS = 3;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);
    localparam logic [SYM_W-1:0]  SYM_BLANK = 2'b11;

    typedef enum logic [1:0] {IDLE, SCROLL, PAUSED} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_d;
    logic [LEN_W-1:0]   offset_q, offset_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               step_d, busy_d, ready_d;
    logic [WIN_W-1:0]   win_d;
    logic [SYM_W-1:0]   sym_buf_q [MAX_LEN];
    logic [SYM_W-1:0]   sym_buf_d [MAX_LEN];
    logic               wr;
    logic [LEN_W-1:0]   cur_period, new_period, idx;
    logic [SYM_W-1:0]   sym;

    // Period of the stream currently being scrolled (message + blank gap).
    assign cur_period = msg_len + LEN_W'(NUM_BLANKS);

    // Next-state, buffer write and window generation.
    always_comb begin
        state_d   = state_q;
        len_d     = msg_len;
        offset_d  = offset_q;
        tick_d    = tick_q;
        step_d    = 1'b0;
        wr        = 1'b0;
        sym_buf_d = sym_buf_q;
        new_period = '0;
        idx       = '0;
        sym       = SYM_BLANK;
        win_d     = '1;

        case (state_q)
            IDLE: begin
                wr    = load.load_valid && load.load_ready;
                len_d = msg_len + LEN_W'(wr);
                // A symbol accepted alongside start belongs to the message.
                if (start && (len_d != '0)) begin
                    state_d  = SCROLL;
                    offset_d = '0;
                    tick_d   = '0;
                end
            end
            SCROLL: begin
                if (stop) begin
                    state_d = IDLE;
                    len_d   = '0;
                end else if (pause_tog) begin
                    state_d = PAUSED;
                end else if (tick_q == TICK_LAST) begin
                    tick_d   = '0;
                    step_d   = 1'b1;
                    offset_d = (offset_q == cur_period - LEN_W'(1)) ? '0
                                                                    : offset_q + LEN_W'(1);
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            PAUSED: begin
                if (stop) begin
                    state_d = IDLE;
                    len_d   = '0;
                end else if (pause_tog) begin
                    state_d = SCROLL;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if (wr && (msg_len == LEN_W'(k))) sym_buf_d[k] = load.load_sym;
        end

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE) && (len_d < LEN_W'(MAX_LEN));

        // offset+i is at most P+4 and P >= 4, so two conditional subtracts
        // always bring the index back into 0..P-1.
        if (state_d != IDLE) begin
            new_period = len_d + LEN_W'(NUM_BLANKS);
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                idx = offset_d + LEN_W'(i);
                if (idx >= new_period) idx = idx - new_period;
                if (idx >= new_period) idx = idx - new_period;
                sym = SYM_BLANK;
                for (int unsigned k = 0; k < MAX_LEN; k++) begin
                    if ((idx == LEN_W'(k)) && (LEN_W'(k) < len_d)) sym = sym_buf_d[k];
                end
                win_d[(NUM_DIGITS - 1 - i) * SYM_W +: SYM_W] = sym;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (clr) begin
            state_q         <= IDLE;
            msg_len         <= '0;
            offset_q        <= '0;
            tick_q          <= '0;
            win             <= '1;
            step            <= 1'b0;
            busy            <= 1'b0;
            load.load_ready <= 1'b1;
        end else begin
            state_q         <= state_d;
            msg_len         <= len_d;
            offset_q        <= offset_d;
            tick_q          <= tick_d;
            win             <= win_d;
            step            <= step_d;
            busy            <= busy_d;
            load.load_ready <= ready_d;
        end
    end

    // Message storage; contents are meaningless until written, so no reset.
    always_ff @(posedge CLOCK_50) begin
        sym_buf_q <= sym_buf_d;
    end

endmodule

// File: tb/tb_scroll_msg_sequencer.sv
// Self-checking bench for scroll_msg_sequencer with TICK_COUNT=4, MAX_LEN=8.
module tb_scroll_msg_sequencer;

    localparam int unsigned TICK_COUNT = 4;
    localparam int unsigned MAX_LEN    = 8;

    logic        CLOCK_50 = 1'b0;
    logic        clr, start, pause_tog, stop;
    logic        busy, step;
    logic [3:0]  msg_len;
    logic [11:0] win;

    scroll_msg_sequencer_if load_if ();

    scroll_msg_sequencer #(.TICK_COUNT(TICK_COUNT), .MAX_LEN(MAX_LEN)) dut (
        .CLOCK_50  (CLOCK_50),
        .clr       (clr),
        .load      (load_if.slave),
        .start     (start),
        .pause_tog (pause_tog),
        .stop      (stop),
        .busy      (busy),
        .msg_len   (msg_len),
        .step      (step),
        .win       (win)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        string       tag;
        logic        clr;
        logic        lv;
        logic [1:0]  sym;
        logic        start;
        logic        pt;
        logic        stop;
        logic [11:0] win;
        logic        step;
        logic        busy;
        logic [3:0]  len;
        logic        ready;
    } vec_t;

    typedef struct packed {
        logic [11:0] win;
        logic        step;
        logic        busy;
        logic [3:0]  len;
        logic        ready;
    } obs_t;

    vec_t  vecs[$];
    obs_t  sb[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic vec_t mk(input string tag, input logic c, input logic lv,
                                input logic [1:0] sym, input logic st, input logic pt,
                                input logic sp, input logic [11:0] w, input logic stp,
                                input logic bsy, input logic [3:0] len, input logic rdy);
        vec_t v;
        v.tag = tag; v.clr = c; v.lv = lv; v.sym = sym; v.start = st; v.pt = pt;
        v.stop = sp; v.win = w; v.step = stp; v.busy = bsy; v.len = len; v.ready = rdy;
        return v;
    endfunction

    // Reference window: digit i shows stream[(off+i) mod (len+3)].
    function automatic logic [11:0] win_model(input logic [1:0] m [8], input int len,
                                              input int off);
        logic [11:0] w;
        int p, k;
        p = len + 3;
        w = '1;
        for (int i = 0; i < 6; i++) begin
            k = (off + i) % p;
            w[(5 - i) * 2 +: 2] = (k < len) ? m[k] : 2'b11;
        end
        return w;
    endfunction

    task automatic check_output();
        obs_t  want, got;
        string tag;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got an output cycle with no expectation queued");
            return;
        end
        want = sb.pop_front();
        tag  = tag_q.pop_front();
        got  = '{win: win, step: step, busy: busy, len: msg_len, ready: load_if.load_ready};
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got win=%h step=%b busy=%b len=%0d ready=%b, want win=%h step=%b busy=%b len=%0d ready=%b",
                     tag, got.win, got.step, got.busy, got.len, got.ready,
                     want.win, want.step, want.busy, want.len, want.ready);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic apply(input vec_t v);
        clr                = v.clr;
        load_if.load_valid = v.lv;
        load_if.load_sym   = v.sym;
        start              = v.start;
        pause_tog          = v.pt;
        stop               = v.stop;
        sb.push_back('{win: v.win, step: v.step, busy: v.busy, len: v.len, ready: v.ready});
        tag_q.push_back(v.tag);
        @(posedge CLOCK_50);
        #1;
        check_output();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [11:0] wins3 [7];
        logic [1:0]  msg8 [8];

        clr = 1'b0; start = 1'b0; pause_tog = 1'b0; stop = 1'b0;
        load_if.load_valid = 1'b0; load_if.load_sym = 2'b00;

        // d,E,L scroll: period 6, hand-derived windows for offsets 0..5 then wrap.
        wins3 = '{12'h1BF, 12'h6FC, 12'hBF1, 12'hFC6, 12'hF1B, 12'hC6F, 12'h1BF};
        msg8  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

        vecs.push_back(mk("reset",  1, 0, 2'd0, 0, 0, 0, 12'hFFF, 0, 0, 4'd0, 1));
        vecs.push_back(mk("load_d", 0, 1, 2'd0, 0, 0, 0, 12'hFFF, 0, 0, 4'd1, 1));
        vecs.push_back(mk("load_E", 0, 1, 2'd1, 0, 0, 0, 12'hFFF, 0, 0, 4'd2, 1));
        vecs.push_back(mk("load_L", 0, 1, 2'd2, 0, 0, 0, 12'hFFF, 0, 0, 4'd3, 1));
        vecs.push_back(mk("start3", 0, 0, 2'd0, 1, 0, 0, wins3[0], 0, 1, 4'd3, 0));
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < 3; c++)
                vecs.push_back(mk("hold3", 0, 0, 2'd0, 0, 0, 0, wins3[s], 0, 1, 4'd3, 0));
            vecs.push_back(mk("step3", 0, 0, 2'd0, 0, 0, 0, wins3[s + 1], 1, 1, 4'd3, 0));
        end
        vecs.push_back(mk("stop_with_pause", 0, 0, 2'd0, 0, 1, 1, 12'hFFF, 0, 0, 4'd0, 1));
        vecs.push_back(mk("start_empty",     0, 0, 2'd0, 1, 0, 0, 12'hFFF, 0, 0, 4'd0, 1));
        vecs.push_back(mk("stop_pause_idle", 0, 0, 2'd0, 0, 1, 1, 12'hFFF, 0, 0, 4'd0, 1));

        // Fill to capacity with load_valid held for a ninth cycle, then scroll 12 steps.
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk("load8", 0, 1, msg8[k], 0, 0, 0, 12'hFFF, 0, 0, 4'(k + 1),
                              (k + 1) < 8));
        vecs.push_back(mk("load_full", 0, 1, 2'd2, 0, 0, 0, 12'hFFF, 0, 0, 4'd8, 0));
        vecs.push_back(mk("start8", 0, 0, 2'd0, 1, 0, 0, win_model(msg8, 8, 0), 0, 1, 4'd8, 0));
        for (int s = 0; s < 12; s++) begin
            for (int c = 0; c < 3; c++)
                vecs.push_back(mk("hold8", 0, (s == 0 && c == 0), 2'd3, 0, 0, 0,
                                  win_model(msg8, 8, s % 11), 0, 1, 4'd8, 0));
            vecs.push_back(mk("step8", 0, 0, 2'd0, 0, 0, 0,
                              win_model(msg8, 8, (s + 1) % 11), 1, 1, 4'd8, 0));
        end
        vecs.push_back(mk("stop8", 0, 0, 2'd0, 0, 0, 1, 12'hFFF, 0, 0, 4'd0, 1));

        for (int n = 0; n < vecs.size(); n++) apply(vecs[n]);

        // Single symbol loaded in the start cycle, then pause mid-count and resume.
        apply(mk("start_with_load", 0, 1, 2'd1, 1, 0, 0, 12'h7F7, 0, 1, 4'd1, 0));
        apply(mk("pre_pause_1",     0, 0, 2'd0, 0, 0, 0, 12'h7F7, 0, 1, 4'd1, 0));
        apply(mk("pre_pause_2",     0, 0, 2'd0, 0, 0, 0, 12'h7F7, 0, 1, 4'd1, 0));
        apply(mk("pause",           0, 0, 2'd0, 0, 1, 0, 12'h7F7, 0, 1, 4'd1, 0));
        for (int c = 0; c < 20; c++)
            apply(mk("paused_hold", 0, 0, 2'd0, 0, 0, 0, 12'h7F7, 0, 1, 4'd1, 0));
        apply(mk("resume",          0, 0, 2'd0, 0, 1, 0, 12'h7F7, 0, 1, 4'd1, 0));
        apply(mk("resume_count",    0, 0, 2'd0, 0, 0, 0, 12'h7F7, 0, 1, 4'd1, 0));
        apply(mk("resume_step",     0, 0, 2'd0, 0, 0, 0, 12'hFDF, 1, 1, 4'd1, 0));
        apply(mk("after_step",      0, 0, 2'd0, 0, 0, 0, 12'hFDF, 0, 1, 4'd1, 0));
        apply(mk("clr_mid_scroll",  1, 0, 2'd0, 0, 0, 0, 12'hFFF, 0, 0, 4'd0, 1));

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
